// File: rtl/snn_pkg.sv
// ----------------------------------------------------------------------------
// snn_pkg : shared constants and scheduler state encoding for the SNN core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package snn_pkg;

    localparam int IMG_IDX_W  = 16;
    localparam int EPOCH_W    = 8;
    localparam int TU_MAX_DEF = 200;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LOAD       = 4'd1,
        ST_LOAD_WAIT  = 4'd2,
        ST_STEP       = 4'd3,
        ST_GEN_WAIT   = 4'd4,
        ST_TU_WAIT    = 4'd5,
        ST_LEARN      = 4'd6,
        ST_LEARN_WAIT = 4'd7,
        ST_CLEAR      = 4'd8,
        ST_NEXT       = 4'd9,
        ST_DONE       = 4'd10
    } state_e;

endpackage

`default_nettype wire

// File: rtl/img_epoch_cnt.sv
// ----------------------------------------------------------------------------
// img_epoch_cnt : image index / epoch counters with dataset wrap
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module img_epoch_cnt
    import snn_pkg::*;
#(
    parameter int N_IMG   = 100,
    parameter int N_EPOCH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 advance_i,
    output logic [IMG_IDX_W-1:0] img_idx_o,
    output logic [EPOCH_W-1:0]   epoch_o,
    output logic                 last_img_o,
    output logic                 last_epoch_o
);

    localparam logic [IMG_IDX_W-1:0] IMG_LAST   = IMG_IDX_W'(N_IMG - 1);
    localparam logic [EPOCH_W-1:0]   EPOCH_LAST = EPOCH_W'(N_EPOCH - 1);

    logic [IMG_IDX_W-1:0] img_q, img_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;

    assign last_img_o   = (img_q == IMG_LAST);
    assign last_epoch_o = (epoch_q == EPOCH_LAST);

    // The epoch saturates at its last value so it reads N_EPOCH-1 after the run.
    always_comb begin
        img_d   = img_q;
        epoch_d = epoch_q;
        if (clr_i) begin
            img_d   = '0;
            epoch_d = '0;
        end else if (advance_i) begin
            if (last_img_o) begin
                img_d = '0;
                if (!last_epoch_o) begin
                    epoch_d = epoch_q + EPOCH_W'(1);
                end
            end else begin
                img_d = img_q + IMG_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q   <= '0;
            epoch_q <= '0;
        end else begin
            img_q   <= img_d;
            epoch_q <= epoch_d;
        end
    end

    assign img_idx_o = img_q;
    assign epoch_o   = epoch_q;

endmodule

`default_nettype wire

// File: rtl/img_scheduler.sv
// ----------------------------------------------------------------------------
// img_scheduler : per-image load / spike / learn / clear sequencer for one core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module img_scheduler
    import snn_pkg::*;
#(
    parameter int N_IMG   = 100,
    parameter int N_EPOCH = 1,
    parameter int TU_MAX  = TU_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 learn_en_i,
    output logic                 img_load_req_o,
    input  logic                 img_loaded_i,
    output logic [IMG_IDX_W-1:0] img_idx_o,
    output logic [EPOCH_W-1:0]   epoch_o,
    output logic                 spk_gen_req_o,
    input  logic                 spk_gen_valid_i,
    output logic                 valid_ips_o,
    output logic                 start_core_img_o,
    input  logic                 tu_incre_i,
    input  logic                 done_core_img_i,
    output logic                 learn_start_o,
    input  logic                 learn_done_i,
    output logic                 neuron_clr_o,
    output logic                 busy_o,
    output logic                 run_done_o,
    output logic                 sync_err_o
);

    localparam int              TU_W    = $clog2(TU_MAX + 1);
    localparam logic [TU_W-1:0] TU_LAST = TU_W'(TU_MAX - 1);

    state_e          state_q, state_d;
    logic [TU_W-1:0] shadow_q, shadow_d;
    logic            sync_err_q, sync_err_d;
    logic            learn_en_q, learn_en_d;
    logic            load_req_q, load_req_d;
    logic            spk_req_q, spk_req_d;
    logic            valid_ips_q, valid_ips_d;
    logic            start_core_q, start_core_d;
    logic            learn_start_q, learn_start_d;
    logic            clr_q, clr_d;
    logic            busy_q, busy_d;
    logic            run_done_q, run_done_d;
    logic            cnt_clr, cnt_adv, last_img, last_epoch;

    img_epoch_cnt #(
        .N_IMG   (N_IMG),
        .N_EPOCH (N_EPOCH)
    ) u_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (cnt_clr),
        .advance_i    (cnt_adv),
        .img_idx_o    (img_idx_o),
        .epoch_o      (epoch_o),
        .last_img_o   (last_img),
        .last_epoch_o (last_epoch)
    );

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        sync_err_d    = sync_err_q;
        learn_en_d    = learn_en_q;
        load_req_d    = 1'b0;
        spk_req_d     = 1'b0;
        valid_ips_d   = 1'b0;
        start_core_d  = 1'b0;
        learn_start_d = 1'b0;
        clr_d         = 1'b0;
        run_done_d    = 1'b0;
        cnt_clr       = 1'b0;
        cnt_adv       = 1'b0;

        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        learn_en_d = learn_en_i;
                        shadow_d   = '0;
                        sync_err_d = 1'b0;
                        cnt_clr    = 1'b1;
                        state_d    = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_req_d   = 1'b1;
                    start_core_d = 1'b1;
                    state_d      = ST_LOAD_WAIT;
                end
                ST_LOAD_WAIT: if (img_loaded_i) state_d = ST_STEP;
                ST_STEP: begin
                    spk_req_d = 1'b1;
                    state_d   = ST_GEN_WAIT;
                end
                ST_GEN_WAIT: begin
                    if (spk_gen_valid_i) begin
                        valid_ips_d = 1'b1;
                        state_d     = ST_TU_WAIT;
                    end
                end
                // The shadow holds the TU count before this increment, so a
                // well-aligned done_core_img meets it at TU_LAST.
                ST_TU_WAIT: begin
                    if (tu_incre_i) begin
                        if (done_core_img_i) begin
                            if (shadow_q != TU_LAST) sync_err_d = 1'b1;
                            shadow_d = '0;
                            state_d  = learn_en_q ? ST_LEARN : ST_CLEAR;
                        end else if (shadow_q == TU_LAST) begin
                            sync_err_d = 1'b1;
                            shadow_d   = '0;
                            state_d    = ST_CLEAR;
                        end else begin
                            shadow_d = shadow_q + TU_W'(1);
                            state_d  = ST_STEP;
                        end
                    end
                end
                ST_LEARN: begin
                    learn_start_d = 1'b1;
                    state_d       = ST_LEARN_WAIT;
                end
                ST_LEARN_WAIT: if (learn_done_i) state_d = ST_CLEAR;
                ST_CLEAR: begin
                    clr_d   = 1'b1;
                    state_d = ST_NEXT;
                end
                ST_NEXT: begin
                    cnt_adv = 1'b1;
                    state_d = (last_img && last_epoch) ? ST_DONE : ST_LOAD;
                end
                ST_DONE: begin
                    run_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shadow_q      <= '0;
            sync_err_q    <= 1'b0;
            learn_en_q    <= 1'b0;
            load_req_q    <= 1'b0;
            spk_req_q     <= 1'b0;
            valid_ips_q   <= 1'b0;
            start_core_q  <= 1'b0;
            learn_start_q <= 1'b0;
            clr_q         <= 1'b0;
            busy_q        <= 1'b0;
            run_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            sync_err_q    <= sync_err_d;
            learn_en_q    <= learn_en_d;
            load_req_q    <= load_req_d;
            spk_req_q     <= spk_req_d;
            valid_ips_q   <= valid_ips_d;
            start_core_q  <= start_core_d;
            learn_start_q <= learn_start_d;
            clr_q         <= clr_d;
            busy_q        <= busy_d;
            run_done_q    <= run_done_d;
        end
    end

    assign img_load_req_o   = load_req_q;
    assign spk_gen_req_o    = spk_req_q;
    assign valid_ips_o      = valid_ips_q;
    assign start_core_img_o = start_core_q;
    assign learn_start_o    = learn_start_q;
    assign neuron_clr_o     = clr_q;
    assign busy_o           = busy_q;
    assign run_done_o       = run_done_q;
    assign sync_err_o       = sync_err_q;

endmodule

`default_nettype wire

// File: doc/img_scheduler.md
Name: img_scheduler

Overview:
- Top-level sequencer for one SNN core.
- Steps through a dataset of images over a number of epochs. For each image it:
  - requests the image load;
  - drives the per-time-unit spike-generation handshake into time_unit;
  - runs an optional learning phase;
  - clears neuron state before the next image.
- Sits between the image memory / spike generator / learning unit and time_unit, and owns the valid_ips and start_core_img inputs of time_unit.

Parameters:
- N_IMG, 100, images per epoch (1..65535)
- N_EPOCH, 1, epochs per run (1..255)
- TU_MAX, 200, time units per image. Must equal the time_unit wrap count; used for the shadow check only.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin run (ignored unless IDLE)
- abort  in  1  synchronous level: return to IDLE next cycle
- learn_en  in  1  sampled at start: enable LEARN phase per image
- img_load_req  out  1  pulse: load image img_idx
- img_loaded  in  1  pulse: image in input buffer
- img_idx  out  16  current image index
- epoch  out  8  current epoch index
- spk_gen_req  out  1  pulse: generate spikes for next TU
- spk_gen_valid  in  1  pulse: spikes ready
- valid_ips  out  1  pulse to time_unit
- start_core_img  out  1  pulse to time_unit at image start
- tu_incre  in  1  from time_unit TU_incre
- done_core_img  in  1  from time_unit
- learn_start  out  1  pulse
- learn_done  in  1  pulse
- neuron_clr  out  1  one-cycle clear of membrane potentials
- busy  out  1  high in any state except IDLE/DONE
- run_done  out  1  pulse on completion of last image of last epoch
- sync_err  out  1  sticky: done_core_img not coincident with shadow count TU_MAX-1

Behaviour:
- Reset (rst=0): state IDLE; every output 0; img_idx=0, epoch=0, shadow TU=0, learn_en_q=0.
- Outputs are registered. Pulses are exactly 1 cycle. Outputs not pulsed in a cycle return to 0.
- States:
  - IDLE: on start, latch learn_en_q, clear img_idx/epoch/shadow/sync_err, go LOAD.
  - LOAD: pulse img_load_req and start_core_img, go LOAD_WAIT.
  - LOAD_WAIT: on img_loaded go STEP.
  - STEP: pulse spk_gen_req, go GEN_WAIT.
  - GEN_WAIT: on spk_gen_valid pulse valid_ips, go TU_WAIT.
  - TU_WAIT: wait for tu_incre. On tu_incre:
    - shadow += 1;
    - if done_core_img is high in the same cycle: set sync_err if shadow != TU_MAX-1, clear shadow, go LEARN if learn_en_q else CLEAR;
    - else if shadow == TU_MAX-1 (shadow expected done but it did not arrive): set sync_err, clear shadow, go CLEAR;
    - else go STEP.
    - done_core_img without tu_incre is ignored.
  - LEARN: pulse learn_start, go LEARN_WAIT.
  - LEARN_WAIT: on learn_done go CLEAR.
  - CLEAR: pulse neuron_clr, go NEXT.
  - NEXT (index advance):
    - if img_idx == N_IMG-1: img_idx=0; if epoch == N_EPOCH-1, go DONE; else epoch+1, go LOAD;
    - else img_idx+1, go LOAD.
  - DONE: pulse run_done, go IDLE. img_idx/epoch keep their final values (0, N_EPOCH-1 after wrap) until the next start.
- Latency:
  - start to img_load_req: 2 cycles.
  - spk_gen_valid to valid_ips: 1 cycle.
  - tu_incre to next spk_gen_req: 2 cycles.
- abort: highest priority in non-IDLE states. Next state IDLE; no pulses that cycle; counters hold; busy=0 next cycle.
- start while busy: ignored.
- Handshake inputs arriving in a state that does not wait for them: ignored, not queued.
- Mid-run reset: immediate return to reset values. Downstream blocks are reset by the same rst.

Decomposition:
- Shared package snn_pkg: state encoding localparams, TU_MAX default, index widths (IMG_IDX_W=16, EPOCH_W=8).
- One natural sub-module: img_epoch_cnt.
  - Inputs: advance.
  - Outputs: img_idx, epoch, last_img, last_epoch.
  - Function: wrap logic for the image and epoch counters.
- FSM and shadow TU check stay in img_scheduler.

Test Plan (N_IMG=3, N_EPOCH=2, TU_MAX=4, responders with 1-3 cycle latency):
- Full run, learn_en=0 -> 6 img_load_req with img_idx 0,1,2,0,1,2 and epoch 0,0,0,1,1,1; 24 valid_ips; 6 neuron_clr; 0 learn_start; one run_done; sync_err=0.
- Full run, learn_en=1 -> 6 learn_start, each preceding neuron_clr; neuron_clr never issued before learn_done.
- done_core_img injected on 3rd tu_incre -> sync_err=1 (sticky), image advances. Missing done on 4th tu_incre -> sync_err=1, CLEAR still issued.
- abort asserted in GEN_WAIT of image 1 -> busy=0 next cycle, no valid_ips; a later start restarts at img_idx=0, epoch=0.
- rst low during TU_WAIT -> all outputs 0 asynchronously; start ignored while busy; stray img_loaded/learn_done in STEP produce no transition.
- Back-to-back spk_gen_valid the cycle after spk_gen_req -> valid_ips exactly 1 cycle later, exactly one per TU.
